// File: rtl/pipeline_hazard_ctrl_if.sv
// Decode-side bundle for the hazard controller: instruction register/flag usage in,
// stall/issue/squash and performance counters out.
interface pipeline_hazard_ctrl_if #(
  parameter int CNT_W = 16
);
  logic             id_valid;
  logic [4:0]       id_rn;
  logic [4:0]       id_rb;
  logic             id_use_rn;
  logic             id_use_rb;
  logic             id_reg_write;
  logic [4:0]       id_rd;
  logic             id_set_flags;
  logic             id_use_flags;
  logic             id_br_taken;
  logic             stall;
  logic             issue;
  logic             squash;
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] retire_cnt;

  modport master (
    output id_valid, id_rn, id_rb, id_use_rn, id_use_rb, id_reg_write,
           id_rd, id_set_flags, id_use_flags, id_br_taken,
    input  stall, issue, squash, stall_cnt, retire_cnt
  );

  modport slave (
    input  id_valid, id_rn, id_rb, id_use_rn, id_use_rb, id_reg_write,
           id_rd, id_set_flags, id_use_flags, id_br_taken,
    output stall, issue, squash, stall_cnt, retire_cnt
  );
endinterface

// File: rtl/pipeline_hazard_ctrl.sv
// Decode interlock: scoreboard of EX/MEM/WB writers stalls on register/flag RAW hazards
// (no forwarding), squashes the fetch slot after a taken branch, counts stalls/retires.
module pipeline_hazard_ctrl #(
  parameter int CNT_W = 16
) (
  input logic                  clk,
  input logic                  reset,
  pipeline_hazard_ctrl_if.slave bus
);

  typedef struct packed {
    logic       v;
    logic       wr;
    logic [4:0] rd;
    logic       sf;
  } sb_entry_t;

  sb_entry_t        sb_ex;
  sb_entry_t        sb_mem;
  sb_entry_t        sb_wb;
  logic             squash_q;
  logic [CNT_W-1:0] stall_cnt_q;
  logic [CNT_W-1:0] retire_cnt_q;

  logic eff_valid;
  logic reg_haz;
  logic flag_haz;
  logic stall_c;
  logic issue_c;

  // X31 reads as zero, so a pending write to it is never a real dependency.
  function automatic logic reg_hit(input sb_entry_t e, input logic use_rn, input logic [4:0] rn,
                                   input logic use_rb, input logic [4:0] rb);
    logic live;
    live = e.v & e.wr & (e.rd != 5'd31);
    return live & ((use_rn & (rn == e.rd)) | (use_rb & (rb == e.rd)));
  endfunction

  always_comb begin
    eff_valid = bus.id_valid & ~squash_q & ~reset;
    reg_haz   = reg_hit(sb_ex,  bus.id_use_rn, bus.id_rn, bus.id_use_rb, bus.id_rb)
              | reg_hit(sb_mem, bus.id_use_rn, bus.id_rn, bus.id_use_rb, bus.id_rb)
              | reg_hit(sb_wb,  bus.id_use_rn, bus.id_rn, bus.id_use_rb, bus.id_rb);
    flag_haz  = bus.id_use_flags & ((sb_ex.v & sb_ex.sf) | (sb_mem.v & sb_mem.sf) | (sb_wb.v & sb_wb.sf));
    stall_c   = eff_valid & (reg_haz | flag_haz);
    issue_c   = eff_valid & ~stall_c;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sb_ex        <= '0;
      sb_mem       <= '0;
      sb_wb        <= '0;
      squash_q     <= 1'b0;
      stall_cnt_q  <= '0;
      retire_cnt_q <= '0;
    end else begin
      sb_ex        <= issue_c ? sb_entry_t'({1'b1, bus.id_reg_write, bus.id_rd, bus.id_set_flags})
                              : sb_entry_t'('0);
      sb_mem       <= sb_ex;
      sb_wb        <= sb_mem;
      // A stalled branch only squashes once it actually issues.
      squash_q     <= issue_c & bus.id_br_taken;
      if (stall_c && (stall_cnt_q != '1))
        stall_cnt_q <= stall_cnt_q + CNT_W'(1);
      if (sb_wb.v && (retire_cnt_q != '1))
        retire_cnt_q <= retire_cnt_q + CNT_W'(1);
    end
  end

  assign bus.stall      = stall_c;
  assign bus.issue      = issue_c;
  assign bus.squash     = squash_q;
  assign bus.stall_cnt  = stall_cnt_q;
  assign bus.retire_cnt = retire_cnt_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench for pipeline_hazard_ctrl: per-cycle expectations queued at drive time,
// popped and checked mid-cycle; counters predicted from the expected stall/issue stream.
module tb_pipeline_hazard_ctrl;
  localparam int CW = 4;

  typedef struct packed {
    logic       valid;
    logic [4:0] rn;
    logic [4:0] rb;
    logic       use_rn;
    logic       use_rb;
    logic       wr;
    logic [4:0] rd;
    logic       sf;
    logic       uf;
    logic       br;
  } instr_t;

  typedef struct {
    logic          stall;
    logic          issue;
    logic          squash;
    logic [CW-1:0] sc;
    logic [CW-1:0] rc;
  } exp_t;

  logic clk;
  logic reset;
  exp_t expq[$];
  int   errors;
  int   checks;

  logic [CW-1:0] m_sc;
  logic [CW-1:0] m_rc;
  logic [2:0]    m_pipe;

  pipeline_hazard_ctrl_if #(.CNT_W(CW)) bus ();

  pipeline_hazard_ctrl #(.CNT_W(CW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic instr_t nop();
    instr_t i;
    i = '0;
    return i;
  endfunction

  function automatic instr_t alu(input int rd, input int rn, input int rm);
    instr_t i;
    i        = '0;
    i.valid  = 1'b1;
    i.rn     = 5'(rn);
    i.rb     = 5'(rm);
    i.use_rn = 1'b1;
    i.use_rb = 1'b1;
    i.wr     = 1'b1;
    i.rd     = 5'(rd);
    return i;
  endfunction

  function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v, input logic inc);
    return (inc && v != {CW{1'b1}}) ? v + CW'(1) : v;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic step(input logic rst, input instr_t in, input logic e_stall,
                      input logic e_issue, input logic e_squash);
    exp_t x;
    exp_t y;
    reset            = rst;
    bus.id_valid     = in.valid;
    bus.id_rn        = in.rn;
    bus.id_rb        = in.rb;
    bus.id_use_rn    = in.use_rn;
    bus.id_use_rb    = in.use_rb;
    bus.id_reg_write = in.wr;
    bus.id_rd        = in.rd;
    bus.id_set_flags = in.sf;
    bus.id_use_flags = in.uf;
    bus.id_br_taken  = in.br;
    x = '{stall: e_stall, issue: e_issue, squash: e_squash, sc: m_sc, rc: m_rc};
    expq.push_back(x);
    @(negedge clk);
    if (expq.size() == 0) begin
      checks++;
      errors++;
      $error("FAIL scoreboard_empty: observed=0 expected=1");
    end else begin
      y = expq.pop_front();
      check("stall",      32'(bus.stall),      32'(y.stall));
      check("issue",      32'(bus.issue),      32'(y.issue));
      check("squash",     32'(bus.squash),     32'(y.squash));
      check("stall_cnt",  32'(bus.stall_cnt),  32'(y.sc));
      check("retire_cnt", 32'(bus.retire_cnt), 32'(y.rc));
    end
    if (rst) begin
      m_sc   = '0;
      m_rc   = '0;
      m_pipe = '0;
    end else begin
      m_sc   = sat_inc(m_sc, e_stall);
      m_rc   = sat_inc(m_rc, m_pipe[2]);
      m_pipe = {m_pipe[1:0], e_issue};
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    instr_t sub_i;
    instr_t stur;
    instr_t subs;
    instr_t blt;
    instr_t b_i;
    instr_t cons;
    instr_t tmp;
    errors = 0;
    checks = 0;
    m_sc   = '0;
    m_rc   = '0;
    m_pipe = '0;
    reset  = 1'b1;
    tmp    = nop();
    bus.id_valid     = 1'b0;
    bus.id_rn        = '0;
    bus.id_rb        = '0;
    bus.id_use_rn    = 1'b0;
    bus.id_use_rb    = 1'b0;
    bus.id_reg_write = 1'b0;
    bus.id_rd        = '0;
    bus.id_set_flags = 1'b0;
    bus.id_use_flags = 1'b0;
    bus.id_br_taken  = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // Reset state, with a valid instruction offered that must be ignored
    step(1'b1, alu(1, 2, 3), 1'b0, 1'b0, 1'b0);

    // Back-to-back RAW: 3 stall cycles, issue in the 4th
    step(1'b0, alu(1, 2, 3), 1'b0, 1'b1, 1'b0);
    sub_i = alu(4, 1, 5);
    repeat (3) step(1'b0, sub_i, 1'b1, 1'b0, 1'b0);
    step(1'b0, sub_i, 1'b0, 1'b1, 1'b0);
    repeat (3) step(1'b0, nop(), 1'b0, 1'b0, 1'b0);
    check("raw_stall_total", 32'(bus.stall_cnt), 32'd3);

    // Independent stream of 10
    for (int i = 0; i < 10; i++)
      step(1'b0, alu(10 + i, 20 + i, 30), 1'b0, 1'b1, 1'b0);
    repeat (4) step(1'b0, nop(), 1'b0, 1'b0, 1'b0);
    check("stream_retire_total", 32'(bus.retire_cnt), 32'd12);

    // XZR never hazards
    step(1'b0, alu(31, 2, 3), 1'b0, 1'b1, 1'b0);
    step(1'b0, alu(5, 31, 31), 1'b0, 1'b1, 1'b0);

    // Distance-2 dependency through id_rb only
    step(1'b0, alu(7, 2, 3), 1'b0, 1'b1, 1'b0);
    step(1'b0, alu(8, 2, 3), 1'b0, 1'b1, 1'b0);
    stur = alu(0, 9, 7);
    stur.wr = 1'b0;
    repeat (2) step(1'b0, stur, 1'b1, 1'b0, 1'b0);
    step(1'b0, stur, 1'b0, 1'b1, 1'b0);

    // SUBS then taken B.LT: 3-cycle flag stall, then one squashed slot
    subs = alu(9, 2, 3);
    subs.sf = 1'b1;
    step(1'b0, subs, 1'b0, 1'b1, 1'b0);
    blt = nop();
    blt.valid = 1'b1;
    blt.uf    = 1'b1;
    blt.br    = 1'b1;
    repeat (3) step(1'b0, blt, 1'b1, 1'b0, 1'b0);
    step(1'b0, blt, 1'b0, 1'b1, 1'b0);
    tmp = alu(10, 9, 9);
    tmp.uf = 1'b1;
    tmp.br = 1'b1;
    step(1'b0, tmp, 1'b0, 1'b0, 1'b1);
    step(1'b0, alu(11, 2, 3), 1'b0, 1'b1, 1'b0);

    // Squashed slot with a real register hazard and taken branch: no stall, no new squash
    b_i = nop();
    b_i.valid = 1'b1;
    b_i.br    = 1'b1;
    step(1'b0, b_i, 1'b0, 1'b1, 1'b0);
    cons = alu(12, 11, 11);
    cons.br = 1'b1;
    step(1'b0, cons, 1'b0, 1'b0, 1'b1);
    cons.br = 1'b0;
    step(1'b0, cons, 1'b1, 1'b0, 1'b0);
    step(1'b0, cons, 1'b0, 1'b1, 1'b0);

    // Reset with producer in MEM and consumer stalled
    step(1'b0, alu(13, 2, 3), 1'b0, 1'b1, 1'b0);
    cons = alu(14, 13, 13);
    step(1'b0, cons, 1'b1, 1'b0, 1'b0);
    step(1'b1, cons, 1'b0, 1'b0, 1'b0);
    check("rst_stall_cnt",  32'(bus.stall_cnt),  32'd0);
    check("rst_retire_cnt", 32'(bus.retire_cnt), 32'd0);
    step(1'b0, cons, 1'b0, 1'b1, 1'b0);

    // 21 forced stall cycles saturate the 4-bit counter at 15
    for (int r = 0; r < 7; r++) begin
      step(1'b0, alu(15, 2, 3), 1'b0, 1'b1, 1'b0);
      repeat (3) step(1'b0, alu(16, 15, 15), 1'b1, 1'b0, 1'b0);
      step(1'b0, alu(16, 15, 15), 1'b0, 1'b1, 1'b0);
    end
    step(1'b0, nop(), 1'b0, 1'b0, 1'b0);
    check("stall_cnt_saturated", 32'(bus.stall_cnt), 32'd15);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
